// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI peripheral: RW config registers, sticky W1C interrupts with mask,
// ID, hardware snapshot, saturating write counter and access-error flag.
module spi_reg_bank #(
  parameter int unsigned      REG_W    = 8,
  parameter int unsigned      NUM_RW   = 8,
  parameter logic [REG_W-1:0] ID_VALUE = REG_W'(8'hA5)
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    ena,
  input  logic                    wr_rdn,
  input  logic [REG_W-2:0]        addr,
  input  logic [REG_W-1:0]        wdata,
  input  logic                    we,
  output logic [REG_W-1:0]        rdata,
  output logic [REG_W-1:0]        status,
  output logic [NUM_RW*REG_W-1:0] cfg_out,
  input  logic [REG_W-1:0]        irq_evt,
  input  logic [REG_W-1:0]        hw_in,
  output logic                    irq
);

  localparam int unsigned AW = REG_W - 1;

  localparam logic [AW-1:0] AddrId      = AW'(7'h70);
  localparam logic [AW-1:0] AddrIrqStat = AW'(7'h71);
  localparam logic [AW-1:0] AddrIrqMask = AW'(7'h72);
  localparam logic [AW-1:0] AddrHwSnap  = AW'(7'h73);
  localparam logic [AW-1:0] AddrWrCount = AW'(7'h74);
  localparam logic [AW-1:0] AddrErr     = AW'(7'h75);

  // The command bit is carried by the interface but the bank only acts on we.
  logic unused_wr_rdn;
  assign unused_wr_rdn = wr_rdn;

  logic [REG_W-1:0] cfg_q [NUM_RW];
  logic [REG_W-1:0] cfg_d [NUM_RW];
  logic [REG_W-1:0] irq_status_q, irq_status_d;
  logic [REG_W-1:0] irq_mask_q, irq_mask_d;
  logic [REG_W-1:0] hw_snap_q, hw_snap_d;
  logic [REG_W-1:0] wr_count_q, wr_count_d;
  logic             err_q, err_d;
  logic [REG_W-1:0] rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic              wr_en;
  logic [NUM_RW-1:0] cfg_hit;
  logic              hit_irq_stat, hit_irq_mask, hit_wr_count, hit_err;
  logic              legal_wr;
  logic              illegal_wr;
  logic [REG_W-1:0]  w1c_mask;
  logic [REG_W-1:0]  read_val;

  // Address decode
  always_comb begin
    cfg_hit = '0;
    for (int k = 0; k < int'(NUM_RW); k++) begin
      cfg_hit[k] = (addr == AW'(k));
    end
    wr_en        = we & ena;
    hit_irq_stat = (addr == AddrIrqStat);
    hit_irq_mask = (addr == AddrIrqMask);
    hit_wr_count = (addr == AddrWrCount);
    hit_err      = (addr == AddrErr);
    legal_wr     = (|cfg_hit) | hit_irq_stat | hit_irq_mask | hit_wr_count | hit_err;
    illegal_wr   = wr_en & ~legal_wr;
    w1c_mask     = (wr_en & hit_irq_stat) ? wdata : '0;
  end

  // Read mux over current register state
  always_comb begin
    read_val = '0;
    for (int k = 0; k < int'(NUM_RW); k++) begin
      if (cfg_hit[k]) begin
        read_val = cfg_q[k];
      end
    end
    case (addr)
      AddrId:      read_val = ID_VALUE;
      AddrIrqStat: read_val = irq_status_q;
      AddrIrqMask: read_val = irq_mask_q;
      AddrHwSnap:  read_val = hw_snap_q;
      AddrWrCount: read_val = wr_count_q;
      AddrErr:     read_val = {{(REG_W-1){1'b0}}, err_q};
      default:     ;
    endcase
  end

  // Next-state
  always_comb begin
    for (int k = 0; k < int'(NUM_RW); k++) begin
      cfg_d[k] = (wr_en && cfg_hit[k]) ? wdata : cfg_q[k];
    end
    irq_status_d = irq_status_q;
    irq_mask_d   = irq_mask_q;
    hw_snap_d    = hw_snap_q;
    wr_count_d   = wr_count_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    irq_d        = irq_q;

    if (ena) begin
      // Set wins over clear on the same bit.
      irq_status_d = (irq_status_q & ~w1c_mask) | irq_evt;
      rdata_d      = read_val;
      irq_d        = |(irq_status_q & irq_mask_q);
      // Freeze the snapshot while it is being addressed so a read sees a stable value.
      if (addr != AddrHwSnap) begin
        hw_snap_d = hw_in;
      end
    end

    if (wr_en) begin
      if (hit_irq_mask) begin
        irq_mask_d = wdata;
      end
      if (hit_wr_count) begin
        wr_count_d = '0;
      end else if (wr_count_q != '1) begin
        wr_count_d = wr_count_q + 1'b1;
      end
      if (illegal_wr) begin
        err_d = 1'b1;
      end else if (hit_err && wdata[0]) begin
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int k = 0; k < int'(NUM_RW); k++) begin
        cfg_q[k] <= '0;
      end
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      hw_snap_q    <= '0;
      wr_count_q   <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NUM_RW); k++) begin
        cfg_q[k] <= cfg_d[k];
      end
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      hw_snap_q    <= hw_snap_d;
      wr_count_q   <= wr_count_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_RW); g++) begin : g_cfg_out
    assign cfg_out[g*REG_W +: REG_W] = cfg_q[g];
  end

  assign rdata  = rdata_q;
  assign irq    = irq_q;
  assign status = {irq_q, err_q, irq_status_q[REG_W-3:0]};

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed steps followed by random traffic against a behavioural model.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rstb, ena, wr_rdn, we, irq;
  logic [6:0]  addr;
  logic [7:0]  wdata, rdata, status, irq_evt, hw_in;
  logic [63:0] cfg_out;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] m_cfg [8];
  logic [7:0] m_st, m_mask, m_snap, m_cnt, m_rdata;
  logic       m_err, m_irq;

  spi_reg_bank dut (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .wr_rdn  (wr_rdn),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .status  (status),
    .cfg_out (cfg_out),
    .irq_evt (irq_evt),
    .hw_in   (hw_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a < 7'd8) return m_cfg[a[2:0]];
    case (a)
      7'h70:   return 8'hA5;
      7'h71:   return m_st;
      7'h72:   return m_mask;
      7'h73:   return m_snap;
      7'h74:   return m_cnt;
      7'h75:   return {7'd0, m_err};
      default: return 8'h00;
    endcase
  endfunction

  // Advance the model with the inputs present before the edge, then compare after it.
  task automatic tick();
    logic [7:0]  rd;
    logic        ir;
    logic        legal;
    logic [63:0] exp_cfg;
    if (!rstb) begin
      foreach (m_cfg[k]) m_cfg[k] = 8'h00;
      m_st = 0; m_mask = 0; m_snap = 0; m_cnt = 0; m_err = 0; m_rdata = 0; m_irq = 0;
    end else if (ena) begin
      rd = m_read(addr);
      ir = (m_st & m_mask) != 8'h00;
      if (addr != 7'h73) m_snap = hw_in;
      if (we && addr == 7'h71) m_st = m_st & ~wdata;
      m_st = m_st | irq_evt;
      if (we) begin
        legal = (addr < 7'd8) || addr == 7'h71 || addr == 7'h72 || addr == 7'h74 ||
                addr == 7'h75;
        if (addr < 7'd8) m_cfg[addr[2:0]] = wdata;
        if (addr == 7'h72) m_mask = wdata;
        if (addr == 7'h74) m_cnt = 0;
        else if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
        if (!legal) m_err = 1'b1;
        else if (addr == 7'h75 && wdata[0]) m_err = 1'b0;
      end
      m_rdata = rd;
      m_irq   = ir;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) exp_cfg[k*8 +: 8] = m_cfg[k];
    chk("mdl_rdata", 64'(rdata), 64'(m_rdata));
    chk("mdl_irq", 64'(irq), 64'(m_irq));
    chk("mdl_status", 64'(status), 64'({m_irq, m_err, m_st[5:0]}));
    chk("mdl_cfg_out", cfg_out, exp_cfg);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1; wr_rdn = 1'b1;
    tick();
    we = 1'b0; wr_rdn = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
    addr = a;
    tick();
    chk(tag, 64'(rdata), 64'(exp));
  endtask

  logic [6:0] pick;

  initial begin
    rstb = 1'b0; ena = 1'b1; wr_rdn = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    irq_evt = '0; hw_in = '0;
    foreach (m_cfg[k]) m_cfg[k] = 8'h00;
    m_st = 0; m_mask = 0; m_snap = 0; m_cnt = 0; m_err = 0; m_rdata = 0; m_irq = 0;
    tick();
    rstb = 1'b1;
    chk("rst_status", 64'(status), 64'h00);
    chk("rst_irq", 64'(irq), 64'h0);
    for (int a = 0; a < 8; a++) rd_chk("rst_cfg", 7'(a), 8'h00);
    rd_chk("rst_id", 7'h70, 8'hA5);
    rd_chk("rst_wrcnt", 7'h74, 8'h00);

    // Write then read back
    addr = 7'h02;
    wr(7'h02, 8'h3C);
    chk("raw_old", 64'(rdata), 64'h00);
    rd_chk("raw_new", 7'h02, 8'h3C);
    chk("cfg2_out", 64'(cfg_out[23:16]), 64'h3C);
    rd_chk("wrcnt_one", 7'h74, 8'h01);

    // Interrupts
    irq_evt = 8'h05; tick(); irq_evt = 8'h00;
    chk("evt_status", 64'(status), 64'h05);
    chk("evt_irq_masked", 64'(irq), 64'h0);
    wr(7'h72, 8'h04);
    chk("irq_lat", 64'(irq), 64'h0);
    tick();
    chk("irq_set", 64'(irq), 64'h1);
    chk("irq_status85", 64'(status), 64'h85);
    irq_evt = 8'h04;
    wr(7'h71, 8'h04);
    irq_evt = 8'h00;
    chk("set_wins", 64'(status), 64'h85);
    wr(7'h71, 8'h01);
    chk("w1c_bit0", 64'(status), 64'h84);

    // Illegal writes and error flag
    wr(7'h74, 8'h99);
    wr(7'h70, 8'h11);
    wr(7'h50, 8'h11);
    rd_chk("id_kept", 7'h70, 8'hA5);
    chk("err_status", 64'(status), 64'hC4);
    rd_chk("undef_rd", 7'h50, 8'h00);
    rd_chk("wrcnt_two", 7'h74, 8'h02);
    rd_chk("err_rd", 7'h75, 8'h01);
    wr(7'h75, 8'h01);
    tick();
    chk("err_clr", 64'(status[6]), 64'h0);

    // Counter saturation and clear
    for (int i = 0; i < 300; i++) wr(7'h00, 8'(i));
    rd_chk("wrcnt_sat", 7'h74, 8'hFF);
    wr(7'h74, 8'h00);
    rd_chk("wrcnt_clr", 7'h74, 8'h00);

    // Snapshot freezes while addressed
    hw_in = 8'h5A; addr = 7'h00; tick();
    addr = 7'h73; hw_in = 8'h11; tick();
    tick();
    chk("snap_hold", 64'(rdata), 64'h5A);
    hw_in = 8'h00;

    // Clock enable low: nothing moves
    ena = 1'b0; irq_evt = 8'hFF;
    wr(7'h01, 8'hAA);
    irq_evt = 8'h00;
    chk("ena_cfg1", 64'(cfg_out[15:8]), 64'h00);
    chk("ena_status", 64'(status), 64'h84);
    chk("ena_rdata", 64'(rdata), 64'h5A);
    ena = 1'b1;

    // Reset with a concurrent write
    rstb = 1'b0;
    wr(7'h03, 8'h77);
    rstb = 1'b1;
    chk("rstw_cfg", cfg_out, 64'h0);
    chk("rstw_status", 64'(status), 64'h00);
    chk("rstw_irq", 64'(irq), 64'h0);
    rd_chk("rstw_wrcnt", 7'h74, 8'h00);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    pick = 7'($urandom_range(0, 7));
        2:       pick = 7'($urandom_range(8'h70, 8'h77));
        default: pick = ($urandom_range(0, 1) == 0) ? 7'h50 : 7'h7F;
      endcase
      addr    = pick;
      wdata   = 8'($urandom);
      we      = ($urandom_range(0, 2) == 0);
      wr_rdn  = we;
      ena     = ($urandom_range(0, 7) != 0);
      rstb    = ($urandom_range(0, 63) != 0);
      irq_evt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      hw_in   = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
